// File: rtl/estacao_reserva_add_if.sv
// Dispatch and CDB signals of one ADD/SUB reservation station.
// The dispatch/CDB side takes the master modport; the station takes slave.
interface estacao_reserva_add_if;
  logic        Enable;
  logic [2:0]  Opcode;
  logic [15:0] Vj;
  logic [15:0] Vk;
  logic [2:0]  Qj;
  logic [2:0]  Qk;
  logic        CDB_Valid;
  logic [2:0]  CDB_Tag;
  logic [15:0] CDB_Data;
  logic        CDB_Grant;
  logic        CDB_Req;
  logic [2:0]  Result_Tag;
  logic [15:0] Result_Data;
  logic        Ready;

  modport master (
    output Enable, Opcode, Vj, Vk, Qj, Qk, CDB_Valid, CDB_Tag, CDB_Data, CDB_Grant,
    input  CDB_Req, Result_Tag, Result_Data, Ready
  );

  modport slave (
    input  Enable, Opcode, Vj, Vk, Qj, Qk, CDB_Valid, CDB_Tag, CDB_Data, CDB_Grant,
    output CDB_Req, Result_Tag, Result_Data, Ready
  );
endinterface

// File: rtl/estacao_reserva_add.sv
// Tomasulo ADD/SUB reservation station: holds one instruction, snoops the CDB
// for missing operands, executes with fixed latency and broadcasts under TAG.
//
// state     | meaning
// FREE      | empty, Ready=1, accepts a dispatch on Enable
// WAIT_OPER | holding an instruction, at least one operand tag still pending
// EXEC      | both operands present, latency counter running
// WRITEBACK | result registered, CDB_Req held until a grant is sampled
module estacao_reserva_add #(
  parameter logic [2:0]  TAG             = 3'd1,
  parameter int          EXEC_LATENCY    = 2,
  parameter logic [15:0] Vj_Vk_sem_valor = 16'hFFF0,
  parameter logic [2:0]  Qj_Qk_sem_valor = 3'd0
) (
  input logic                 Clock,
  input logic                 Reset,
  estacao_reserva_add_if.slave rs
);

  localparam int CW = (EXEC_LATENCY > 1) ? $clog2(EXEC_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(EXEC_LATENCY - 1);

  typedef enum logic [1:0] {FREE, WAIT_OPER, EXEC, WRITEBACK} state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [15:0]   vj_q, vj_d, vk_q, vk_d;
  logic [2:0]    qj_q, qj_d, qk_q, qk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   res_q, res_d;

  logic [15:0] vj_s, vk_s, vj_r, vk_r, alu;
  logic [2:0]  qj_s, qk_s, qj_r, qk_r;
  logic        hit_j, hit_k;

  // In FREE the snoop applies to the incoming dispatch (same-edge forwarding),
  // otherwise to the held tags.
  always_comb begin
    vj_s  = vj_q;
    vk_s  = vk_q;
    qj_s  = qj_q;
    qk_s  = qk_q;
    if (state_q == FREE) begin
      vj_s = rs.Vj;
      vk_s = rs.Vk;
      qj_s = rs.Qj;
      qk_s = rs.Qk;
    end
    hit_j = rs.CDB_Valid && (qj_s != Qj_Qk_sem_valor) && (rs.CDB_Tag == qj_s);
    hit_k = rs.CDB_Valid && (qk_s != Qj_Qk_sem_valor) && (rs.CDB_Tag == qk_s);
    vj_r  = hit_j ? rs.CDB_Data : vj_s;
    vk_r  = hit_k ? rs.CDB_Data : vk_s;
    qj_r  = hit_j ? Qj_Qk_sem_valor : qj_s;
    qk_r  = hit_k ? Qj_Qk_sem_valor : qk_s;
  end

  always_comb begin
    case (op_q)
      3'b000:  alu = vj_q + vk_q;
      3'b001:  alu = vj_q - vk_q;
      default: alu = vj_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      FREE: begin
        if (rs.Enable) begin
          op_d = rs.Opcode;
          vj_d = vj_r;
          vk_d = vk_r;
          qj_d = qj_r;
          qk_d = qk_r;
          if (qj_r == Qj_Qk_sem_valor && qk_r == Qj_Qk_sem_valor) begin
            state_d = EXEC;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = WAIT_OPER;
          end
        end
      end
      WAIT_OPER: begin
        vj_d = vj_r;
        vk_d = vk_r;
        qj_d = qj_r;
        qk_d = qk_r;
        if (qj_r == Qj_Qk_sem_valor && qk_r == Qj_Qk_sem_valor) begin
          state_d = EXEC;
          cnt_d   = CNT_LOAD;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          res_d   = alu;
          state_d = WRITEBACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WRITEBACK: begin
        if (rs.CDB_Grant) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= FREE;
      op_q    <= 3'd0;
      vj_q    <= Vj_Vk_sem_valor;
      vk_q    <= Vj_Vk_sem_valor;
      qj_q    <= Qj_Qk_sem_valor;
      qk_q    <= Qj_Qk_sem_valor;
      cnt_q   <= '0;
      res_q   <= Vj_Vk_sem_valor;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vj_q    <= vj_d;
      vk_q    <= vk_d;
      qj_q    <= qj_d;
      qk_q    <= qk_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign rs.Ready       = (state_q == FREE);
  assign rs.CDB_Req     = (state_q == WRITEBACK);
  assign rs.Result_Tag  = (state_q == WRITEBACK) ? TAG : 3'd0;
  assign rs.Result_Data = (state_q == WRITEBACK) ? res_q : Vj_Vk_sem_valor;

endmodule

// File: tb/tb_estacao_reserva_add.sv
// Bench for estacao_reserva_add: directed and random transactions checked
// against a transaction-level model of operand resolution, latency and result.
module tb_estacao_reserva_add;
  localparam logic [2:0] TAG = 3'd1;
  localparam int         LAT = 2;
  localparam logic [15:0] NOVAL = 16'hFFF0;

  logic Clock = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_errors = 0;

  estacao_reserva_add_if bus ();

  estacao_reserva_add #(.TAG(TAG), .EXEC_LATENCY(LAT)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .rs    (bus.slave)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    if (op == 3'b000) return 16'((32'(a) + 32'(b)) % 32'h10000);
    if (op == 3'b001) return 16'((32'(a) + 32'h10000 - 32'(b)) % 32'h10000);
    return a;
  endfunction

  task automatic idle_inputs();
    bus.Enable    = 1'b0;
    bus.Opcode    = 3'd0;
    bus.Vj        = 16'd0;
    bus.Vk        = 16'd0;
    bus.Qj        = 3'd0;
    bus.Qk        = 3'd0;
    bus.CDB_Valid = 1'b0;
    bus.CDB_Tag   = 3'd0;
    bus.CDB_Data  = 16'd0;
    bus.CDB_Grant = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 32'(bus.Ready), 32'd1);
    chk({tag, "_req"},   32'(bus.CDB_Req), 32'd0);
    chk({tag, "_rtag"},  32'(bus.Result_Tag), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.Result_Data), 32'(NOVAL));
  endtask

  // One instruction from dispatch to grant. Edge 0 is the accepting edge;
  // operand j arrives on the CDB at edge tj (0 = forwarded on the dispatch edge).
  task automatic run_txn(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                         input logic [2:0] qj, input logic [2:0] qk,
                         input int tj_in, input int tk_in,
                         input logic [15:0] dj, input logic [15:0] dk_in,
                         input int g, input bit noise);
    int tj, tk, r, wb, last;
    logic [15:0] dk, ej, ek, exp_res;
    logic [2:0] nt;
    tj = tj_in;
    tk = tk_in;
    dk = dk_in;
    if (qj != 0 && qj == qk) begin
      tk = tj;
      dk = dj;
    end else if (qj != 0 && qk != 0 && tj == tk) begin
      tk = tj + 1;
    end
    ej = (qj == 0) ? vj : dj;
    ek = (qk == 0) ? vk : dk;
    exp_res = ref_result(op, ej, ek);
    r = 0;
    if (qj != 0) r = tj;
    if (qk != 0 && tk > r) r = tk;
    wb   = r + LAT;
    last = wb + g + 1;
    chk("pre_ready", 32'(bus.Ready), 32'd1);
    for (int e = 0; e <= last; e++) begin
      bus.Enable    = (e == 0) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      bus.Opcode    = (e == 0) ? op : 3'($urandom);
      bus.Vj        = (e == 0) ? vj : 16'($urandom);
      bus.Vk        = (e == 0) ? vk : 16'($urandom);
      bus.Qj        = (e == 0) ? qj : 3'($urandom);
      bus.Qk        = (e == 0) ? qk : 3'($urandom);
      bus.CDB_Valid = 1'b0;
      bus.CDB_Tag   = 3'd0;
      bus.CDB_Data  = 16'($urandom);
      if (qj != 0 && e == tj) begin
        bus.CDB_Valid = 1'b1;
        bus.CDB_Tag   = qj;
        bus.CDB_Data  = dj;
      end else if (qk != 0 && e == tk) begin
        bus.CDB_Valid = 1'b1;
        bus.CDB_Tag   = qk;
        bus.CDB_Data  = dk;
      end else if (noise && $urandom_range(0, 1) == 1) begin
        nt = 3'($urandom_range(0, 7));
        if (e <= r && (nt == qj || nt == qk)) nt = 3'd0;
        bus.CDB_Valid = 1'b1;
        bus.CDB_Tag   = nt;
      end
      if (e == last)                bus.CDB_Grant = 1'b1;
      else if (noise && e <= wb)    bus.CDB_Grant = 1'($urandom_range(0, 1));
      else                          bus.CDB_Grant = 1'b0;
      @(posedge Clock);
      @(negedge Clock);
      if (e < last) begin
        chk("busy_ready", 32'(bus.Ready), 32'd0);
        chk("req", 32'(bus.CDB_Req), (e >= wb) ? 32'd1 : 32'd0);
        chk("rtag", 32'(bus.Result_Tag), (e >= wb) ? 32'(TAG) : 32'd0);
        chk("rdata", 32'(bus.Result_Data), (e >= wb) ? 32'(exp_res) : 32'(NOVAL));
      end else begin
        chk_idle("granted");
      end
    end
    idle_inputs();
  endtask

  initial begin
    logic [2:0]  op, qj, qk;
    logic [15:0] vj, vk;
    idle_inputs();
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    chk_idle("in_reset");
    Reset = 1'b0;
    @(negedge Clock);
    chk_idle("after_reset");

    // ADD 5+7, SUB wrap, ADD wrap
    run_txn(3'b000, 16'd5, 16'd7, 3'd0, 3'd0, 0, 0, 16'd0, 16'd0, 0, 1'b0);
    run_txn(3'b001, 16'd3, 16'd5, 3'd0, 3'd0, 0, 0, 16'd0, 16'd0, 1, 1'b0);
    run_txn(3'b000, 16'hFFFF, 16'd1, 3'd0, 3'd0, 0, 0, 16'd0, 16'd0, 0, 1'b0);
    // Qj pending for three cycles, then tag 2 broadcast with data 4
    run_txn(3'b000, 16'd0, 16'd10, 3'd2, 3'd0, 4, 0, 16'd4, 16'd0, 0, 1'b1);
    // Qj == Qk, one broadcast feeds both
    run_txn(3'b000, 16'd0, 16'd0, 3'd2, 3'd2, 2, 2, 16'd9, 16'd9, 0, 1'b0);
    // same-edge forwarding
    run_txn(3'b000, 16'd0, 16'd3, 3'd2, 3'd0, 0, 0, 16'd1, 16'd0, 0, 1'b0);
    // long writeback stall with noise (Enable pulses, stray grants earlier)
    run_txn(3'b101, 16'h1234, 16'd8, 3'd0, 3'd0, 0, 0, 16'd0, 16'd0, 5, 1'b1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 3));
      if (op == 3'd3) op = 3'($urandom_range(2, 7));
      vj = 16'($urandom);
      vk = 16'($urandom);
      qj = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      qk = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      run_txn(op, vj, vk, qj, qk, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              16'($urandom), 16'($urandom), int'($urandom_range(0, 4)), 1'b1);
    end

    // reset during EXEC abandons the instruction
    bus.Enable = 1'b1;
    bus.Opcode = 3'b000;
    bus.Vj     = 16'd20;
    bus.Vk     = 16'd22;
    @(posedge Clock);
    @(negedge Clock);
    idle_inputs();
    chk("exec_ready", 32'(bus.Ready), 32'd0);
    @(posedge Clock);
    #1 Reset = 1'b1;
    #1 chk_idle("mid_reset");
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      chk("post_reset_req", 32'(bus.CDB_Req), 32'd0);
      chk("post_reset_ready", 32'(bus.Ready), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
